// File: rtl/pet_pkg.sv
// Shared definitions for the pet action menu: FSM states, action indices and
// bus widths, plus small helpers for the one-hot action bus and cursor wrap.
package pet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BROWSE   = 2'd1,
    ST_FIRE     = 2'd2,
    ST_COOLDOWN = 2'd3
  } pet_state_e;

  localparam int NUM_ACTIONS = 6;
  localparam int ACTION_W    = 8;
  localparam int CURSOR_W    = 3;

  localparam logic [CURSOR_W-1:0] ACT_FEED   = 3'd0;
  localparam logic [CURSOR_W-1:0] ACT_PLAY   = 3'd1;
  localparam logic [CURSOR_W-1:0] ACT_HEAL   = 3'd2;
  localparam logic [CURSOR_W-1:0] ACT_CLEAN  = 3'd3;
  localparam logic [CURSOR_W-1:0] ACT_SLEEP  = 3'd4;
  localparam logic [CURSOR_W-1:0] ACT_SOCIAL = 3'd5;

  // Out-of-range cursor values map to an empty command rather than a stray bit.
  function automatic logic [ACTION_W-1:0] action_onehot(input logic [CURSOR_W-1:0] idx);
    logic [ACTION_W-1:0] vec;
    case (idx)
      ACT_FEED:   vec = 8'h01;
      ACT_PLAY:   vec = 8'h02;
      ACT_HEAL:   vec = 8'h04;
      ACT_CLEAN:  vec = 8'h08;
      ACT_SLEEP:  vec = 8'h10;
      ACT_SOCIAL: vec = 8'h20;
      default:    vec = 8'h00;
    endcase
    return vec;
  endfunction

  function automatic logic [CURSOR_W-1:0] cursor_next(input logic [CURSOR_W-1:0] idx);
    logic [CURSOR_W-1:0] nxt;
    if (idx >= CURSOR_W'(NUM_ACTIONS - 1)) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pet_action_ctrl_if.sv
// Board-side bundle of the pet action controller: raw buttons and energy in,
// action command, cursor and menu status out.
interface pet_action_ctrl_if;
  import pet_pkg::ACTION_W;
  import pet_pkg::CURSOR_W;

  logic                btn_next;
  logic                btn_select;
  logic                btn_cancel;
  logic [3:0]          energy;
  logic [ACTION_W-1:0] action;
  logic [CURSOR_W-1:0] cursor;
  logic                menu_active;
  logic                busy;
  logic                rejected;

  modport master (
    output btn_next, btn_select, btn_cancel, energy,
    input  action, cursor, menu_active, busy, rejected
  );

  modport slave (
    input  btn_next, btn_select, btn_cancel, energy,
    output action, cursor, menu_active, busy, rejected
  );
endinterface

// File: rtl/btn_debounce.sv
// One raw button: 2-flop synchronizer, stability counter and a registered
// one-cycle press pulse on the rising edge of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_r;
  logic             sync_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             press_r;

  // Synchronize, then flip the level only after a full run of disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      press_r <= 1'b0;
    end else begin
      meta_r <= btn_raw;
      sync_r <= meta_r;
      if (sync_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync_r;
          cnt_r   <= {CNT_W{1'b0}};
          press_r <= sync_r;
        end else begin
          cnt_r   <= cnt_r + CNT_W'(1);
          press_r <= 1'b0;
        end
      end else begin
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= 1'b0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/pet_action_ctrl.sv
// Pet action menu: debounced buttons drive an IDLE/BROWSE/FIRE/COOLDOWN menu
// that emits one-cycle one-hot action commands to the stats block.
module pet_action_ctrl
  import pet_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 64,
  parameter int MENU_TIMEOUT    = 4096
) (
  input logic              clk,
  input logic              reset,
  pet_action_ctrl_if.slave bus
);
  localparam int TMO_W  = $clog2(MENU_TIMEOUT + 1);
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MENU_TIMEOUT - 1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(COOLDOWN_CYCLES - 1);

  logic press_next_s;
  logic press_select_s;
  logic press_cancel_s;
  logic ev_next_s;
  logic ev_select_s;
  logic ev_cancel_s;

  pet_state_e          state_r;
  logic [CURSOR_W-1:0] cursor_r;
  logic [ACTION_W-1:0] action_r;
  logic                rejected_r;
  logic                menu_active_r;
  logic                busy_r;
  logic [TMO_W-1:0]    tmo_r;
  logic [COOL_W-1:0]   cool_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_next),
    .press   (press_next_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_select (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_select),
    .press   (press_select_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cancel (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (bus.btn_cancel),
    .press   (press_cancel_s)
  );

  // Keep only the highest-priority event: cancel, then select, then next.
  always_comb begin
    ev_cancel_s = 1'b0;
    ev_select_s = 1'b0;
    ev_next_s   = 1'b0;
    if (press_cancel_s) begin
      ev_cancel_s = 1'b1;
    end else if (press_select_s) begin
      ev_select_s = 1'b1;
    end else begin
      ev_next_s = press_next_s;
    end
  end

  // Menu FSM; every output is set here alongside the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cursor_r      <= 3'd0;
      action_r      <= 8'h00;
      rejected_r    <= 1'b0;
      menu_active_r <= 1'b0;
      busy_r        <= 1'b0;
      tmo_r         <= {TMO_W{1'b0}};
      cool_r        <= {COOL_W{1'b0}};
    end else begin
      action_r   <= 8'h00;
      rejected_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cursor_r <= 3'd0;
          busy_r   <= 1'b0;
          tmo_r    <= {TMO_W{1'b0}};
          if (ev_next_s || ev_select_s) begin
            state_r       <= ST_BROWSE;
            menu_active_r <= 1'b1;
          end else begin
            menu_active_r <= 1'b0;
          end
        end
        ST_BROWSE: begin
          if (ev_cancel_s) begin
            state_r       <= ST_IDLE;
            cursor_r      <= 3'd0;
            menu_active_r <= 1'b0;
            tmo_r         <= {TMO_W{1'b0}};
          end else if (ev_select_s) begin
            state_r <= ST_FIRE;
            busy_r  <= 1'b1;
            tmo_r   <= {TMO_W{1'b0}};
            // Energy is looked at here, in the cycle the menu commits to FIRE.
            if ((cursor_r == ACT_PLAY) && (bus.energy == 4'd0)) begin
              rejected_r <= 1'b1;
            end else begin
              action_r <= action_onehot(cursor_r);
            end
          end else if (ev_next_s) begin
            cursor_r <= cursor_next(cursor_r);
            tmo_r    <= {TMO_W{1'b0}};
          end else if (tmo_r == TMO_LAST) begin
            state_r       <= ST_IDLE;
            cursor_r      <= 3'd0;
            menu_active_r <= 1'b0;
            tmo_r         <= {TMO_W{1'b0}};
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        ST_FIRE: begin
          state_r <= ST_COOLDOWN;
          cool_r  <= {COOL_W{1'b0}};
        end
        ST_COOLDOWN: begin
          // Button events arriving here are dropped, not queued.
          if (cool_r == COOL_LAST) begin
            state_r <= ST_BROWSE;
            busy_r  <= 1'b0;
            cool_r  <= {COOL_W{1'b0}};
            tmo_r   <= {TMO_W{1'b0}};
          end else begin
            cool_r <= cool_r + COOL_W'(1);
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          cursor_r      <= 3'd0;
          menu_active_r <= 1'b0;
          busy_r        <= 1'b0;
          tmo_r         <= {TMO_W{1'b0}};
          cool_r        <= {COOL_W{1'b0}};
        end
      endcase
    end
  end

  assign bus.action      = action_r;
  assign bus.cursor      = cursor_r;
  assign bus.menu_active = menu_active_r;
  assign bus.busy        = busy_r;
  assign bus.rejected    = rejected_r;

endmodule

// File: tb/tb_pet_action_ctrl.sv
// Self-checking bench for pet_action_ctrl: directed menu scenarios followed by
// random button traffic, all compared every cycle against a timestamp model.
module tb_pet_action_ctrl;
  localparam int DEB  = 4;
  localparam int COOL = 8;
  localparam int TMO  = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  pet_action_ctrl_if bus();

  pet_action_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .COOLDOWN_CYCLES (COOL),
    .MENU_TIMEOUT    (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int act_cnt  = 0;
  int rej_cnt  = 0;
  int busy_cnt = 0;
  logic [7:0] last_act = 8'h00;

  // Reference model: modes 0 idle, 1 browse, 2 fire, 3 cooldown; timing by edge stamps.
  int         m_cyc, m_mode, m_cur, m_last, m_fire;
  logic [7:0] m_act;
  logic       m_rej;
  bit [15:0]  m_hist [3];
  bit         m_lvl [3];
  bit         m_ev [3];   // 0 next, 1 select, 2 cancel

  function automatic void model_reset();
    m_cyc = 0; m_mode = 0; m_cur = 0; m_last = 0; m_fire = 0;
    m_act = 8'h00; m_rej = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_hist[b] = 16'h0; m_lvl[b] = 1'b0; m_ev[b] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    bit raw [3];
    bit all_diff;
    m_cyc++;
    m_act = 8'h00;
    m_rej = 1'b0;
    case (m_mode)
      0: if (!m_ev[2] && (m_ev[1] || m_ev[0])) begin
           m_mode = 1; m_cur = 0; m_last = m_cyc;
         end
      1: if (m_ev[2]) begin
           m_mode = 0; m_cur = 0;
         end else if (m_ev[1]) begin
           m_mode = 2; m_fire = m_cyc;
           if (m_cur == 1 && bus.energy == 4'd0) m_rej = 1'b1;
           else m_act = 8'h01 << m_cur;
         end else if (m_ev[0]) begin
           m_cur = (m_cur + 1) % 6; m_last = m_cyc;
         end else if (m_cyc - m_last >= TMO) begin
           m_mode = 0; m_cur = 0;
         end
      2: m_mode = 3;
      default: if (m_cyc == m_fire + 1 + COOL) begin
                 m_mode = 1; m_last = m_cyc;
               end
    endcase
    raw[0] = bus.btn_next; raw[1] = bus.btn_select; raw[2] = bus.btn_cancel;
    for (int b = 0; b < 3; b++) begin
      // Level flips once the last DEB synced samples all disagree with it.
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      all_diff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (m_hist[b][j] == m_lvl[b]) all_diff = 1'b0;
      m_ev[b] = 1'b0;
      if (all_diff) begin
        m_lvl[b] = ~m_lvl[b];
        m_ev[b]  = m_lvl[b];
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("action", bus.action, m_act);
    chk("rejected", {7'd0, bus.rejected}, {7'd0, m_rej});
    chk("cursor", {5'd0, bus.cursor}, 8'(m_cur));
    chk("menu_active", {7'd0, bus.menu_active}, {7'd0, m_mode != 0});
    chk("busy", {7'd0, bus.busy}, {7'd0, m_mode >= 2});
    if (bus.action != 8'h00) begin act_cnt++; last_act = bus.action; end
    if (bus.rejected) rej_cnt++;
    if (bus.busy) busy_cnt++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_action", bus.action, 8'h00);
    chk("rst_cursor", {5'd0, bus.cursor}, 8'h00);
    chk("rst_menu_active", {7'd0, bus.menu_active}, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_rejected", {7'd0, bus.rejected}, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_raw(input int b, input logic v);
    case (b)
      0: bus.btn_next = v;
      1: bus.btn_select = v;
      default: bus.btn_cancel = v;
    endcase
  endtask

  task automatic press(input int b);
    set_raw(b, 1'b1);
    repeat (DEB + 3) tick();
    set_raw(b, 1'b0);
    repeat (DEB + 3) tick();
  endtask

  initial begin
    int n;
    bus.btn_next = 1'b0; bus.btn_select = 1'b0; bus.btn_cancel = 1'b0;
    bus.energy = 4'd5;
    do_reset();
    repeat (3) tick();

    // Short glitch, then a long hold giving exactly one event.
    bus.btn_next = 1'b1; repeat (3) tick();
    bus.btn_next = 1'b0; repeat (8) tick();
    chk("glitch_idle", {7'd0, bus.menu_active}, 8'h00);
    bus.btn_next = 1'b1; repeat (10) tick();
    chk("hold_menu", {7'd0, bus.menu_active}, 8'h01);
    chk("hold_cursor", {5'd0, bus.cursor}, 8'h00);
    bus.btn_next = 1'b0; repeat (8) tick();
    chk("hold_once", {5'd0, bus.cursor}, 8'h00);

    // Cursor wrap, then fire play with energy.
    for (int i = 0; i < 7; i++) begin
      press(0);
      chk("wrap_cursor", {5'd0, bus.cursor}, 8'((i + 1) % 6));
    end
    busy_cnt = 0; act_cnt = 0;
    press(1); repeat (10) tick();
    chk("play_action", last_act, 8'h02);
    chk("play_pulses", 8'(act_cnt), 8'd1);
    chk("busy_cycles", 8'(busy_cnt), 8'd9);
    chk("back_cursor", {5'd0, bus.cursor}, 8'h01);
    chk("back_menu", {7'd0, bus.menu_active}, 8'h01);

    // Play blocked at zero energy; sleep still allowed.
    bus.energy = 4'd0; act_cnt = 0; rej_cnt = 0; busy_cnt = 0;
    press(1); repeat (10) tick();
    chk("block_rej", 8'(rej_cnt), 8'd1);
    chk("block_act", 8'(act_cnt), 8'd0);
    chk("block_busy", 8'(busy_cnt), 8'd9);
    repeat (3) press(0);
    chk("sleep_cursor", {5'd0, bus.cursor}, 8'h04);
    press(1); repeat (10) tick();
    chk("sleep_action", last_act, 8'h10);
    chk("sleep_rej", 8'(rej_cnt), 8'd1);

    // Next event landing inside cooldown is discarded.
    bus.energy = 4'd5; act_cnt = 0;
    bus.btn_select = 1'b1; repeat (3) tick();
    bus.btn_next = 1'b1; repeat (4) tick();
    bus.btn_select = 1'b0; repeat (3) tick();
    bus.btn_next = 1'b0; repeat (17) tick();
    chk("cool_cursor", {5'd0, bus.cursor}, 8'h04);
    chk("cool_pulses", 8'(act_cnt), 8'd1);

    // Cancel beats select.
    act_cnt = 0;
    bus.btn_select = 1'b1; bus.btn_cancel = 1'b1; repeat (7) tick();
    bus.btn_select = 1'b0; bus.btn_cancel = 1'b0; repeat (7) tick();
    chk("prio_menu", {7'd0, bus.menu_active}, 8'h00);
    chk("prio_act", 8'(act_cnt), 8'd0);

    // Timeout: an event in the last idle cycle restarts the count.
    press(0);
    repeat (3) press(0);
    chk("tmo_cursor", {5'd0, bus.cursor}, 8'h03);
    n = 0;
    while (m_cyc != m_last + TMO - 3 - DEB && n < 100) begin tick(); n++; end
    chk("tmo_wait1", {7'd0, m_cyc == m_last + TMO - 3 - DEB}, 8'h01);
    bus.btn_next = 1'b1; repeat (DEB + 3) tick();
    bus.btn_next = 1'b0;
    chk("tmo_restart_menu", {7'd0, bus.menu_active}, 8'h01);
    chk("tmo_restart_cursor", {5'd0, bus.cursor}, 8'h04);
    n = 0;
    while (m_cyc != m_last + TMO - 1 && n < 100) begin tick(); n++; end
    chk("tmo_wait2", {7'd0, m_cyc == m_last + TMO - 1}, 8'h01);
    chk("tmo_last_cycle", {7'd0, bus.menu_active}, 8'h01);
    tick();
    chk("tmo_menu", {7'd0, bus.menu_active}, 8'h00);
    chk("tmo_cursor0", {5'd0, bus.cursor}, 8'h00);

    // Async reset three cycles into cooldown.
    press(0);
    bus.btn_select = 1'b1;
    n = 0;
    while (!(m_mode == 3 && m_cyc == m_fire + 3) && n < 60) begin tick(); n++; end
    chk("rst_cool_wait", {7'd0, m_mode == 3 && m_cyc == m_fire + 3}, 8'h01);
    chk("rst_cool_busy", {7'd0, bus.busy}, 8'h01);
    bus.btn_select = 1'b0;
    do_reset();
    repeat (8) tick();

    // Async reset mid-debounce: held button then needs a full period again.
    bus.btn_next = 1'b1; repeat (3) tick();
    do_reset();
    repeat (DEB + 2) tick();
    chk("redeb_early", {7'd0, bus.menu_active}, 8'h00);
    tick();
    chk("redeb_menu", {7'd0, bus.menu_active}, 8'h01);
    chk("redeb_cursor", {5'd0, bus.cursor}, 8'h00);
    bus.btn_next = 1'b0; repeat (8) tick();

    // Random traffic on all buttons and energy.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) bus.btn_next = ~bus.btn_next;
      if ($urandom_range(0, 11) == 0) bus.btn_select = ~bus.btn_select;
      if ($urandom_range(0, 29) == 0) bus.btn_cancel = ~bus.btn_cancel;
      if ($urandom_range(0, 15) == 0) bus.energy = 4'($urandom_range(0, 2));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
